wbu_arb: RTL and testbench
==========================

Name: wbu_arb

Overview:
- Parametrised multi-source writeback unit with a registered writeback stage.
- Accepts up to NUM_SRC independent result producers (ALU/pc_inc path, DMEM, CSR, MUL, long-latency DIV), each with a valid/ready handshake.
- Selects one producer per cycle and presents one registered write to the register file.
- Lower-index sources win by default; an aging counter stops any source from starving.

Parameters:
- NUM_SRC, 4, number of result sources (2..8).
- DATA_WIDTH, 32, writeback data width.
- RD_WIDTH, 5, destination register index width.
- STARVE_LIMIT, 7, wait cycles after which a source becomes urgent (1..255).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_src_valid  in  NUM_SRC  per-source result valid.
- i_src_rd  in  NUM_SRC*RD_WIDTH  per-source destination index; slice k is [k*RD_WIDTH +: RD_WIDTH].
- i_src_data  in  NUM_SRC*DATA_WIDTH  per-source result data; slice k likewise.
- o_src_ready  out  NUM_SRC  one-hot-or-zero grant; combinational from this cycle's inputs and state.
- o_wb_en  out  1  register-file write enable (registered).
- o_wb_rd  out  RD_WIDTH  write index (registered).
- o_wb_data  out  DATA_WIDTH  write data (registered).
- o_busy  out  1  at least one valid source was not granted this cycle (combinational).

Behaviour:
- Reset: o_wb_en=0, o_wb_rd=0, o_wb_data=0, all age counters=0. o_src_ready is 0 while i_rst is high.
- Handshake:
  - Transfer for source k happens when i_src_valid[k] && o_src_ready[k].
  - At most one ready bit is high per cycle.
  - Ready never asserts without valid.
  - A source holds valid, rd and data stable until it transfers.
- Arbitration, evaluated each cycle:
  - Urgent set = sources with valid and age==STARVE_LIMIT.
  - If the urgent set is non-empty, grant its lowest index.
  - Otherwise grant the lowest-index valid source.
- Age counter k, per cycle:
  - Cleared to 0 when valid[k]=0 or when source k is granted.
  - Otherwise incremented, saturating at STARVE_LIMIT.
  - Width is clog2(STARVE_LIMIT+1).
- Writeback stage, latency 1 cycle from transfer to o_wb_*:
  - On a transfer: o_wb_rd<=granted rd, o_wb_data<=granted data, o_wb_en<=(granted rd!=0).
  - rd==0 transfers are accepted (ready high) but never write; o_wb_en stays 0 for them.
  - No transfer: o_wb_en<=0; o_wb_rd and o_wb_data hold their previous values.
- Flow control: no backpressure from the register file; one write per cycle, every cycle. Throughput is 1 result/cycle aggregate.
- Simultaneous events: several sources becoming valid in the same cycle is resolved purely by the arbitration rule. Order among the losers follows the age counters.
- Reset mid-operation: async assertion clears o_wb_en immediately and clears all ages. Held source requests are re-arbitrated from zero age after release.
- o_busy = |(i_src_valid & ~o_src_ready).

Optional Feature:
- Macro: WBU_ARB_FWD_EN.
- Defined:
  - Adds inputs i_fwd_rs1, i_fwd_rs2 (RD_WIDTH each).
  - Adds outputs o_fwd_rs1_hit, o_fwd_rs2_hit (1 each) and o_fwd_data (DATA_WIDTH).
  - hit = o_wb_en && (o_wb_rd==i_fwd_rsN) && (i_fwd_rsN!=0), combinational from the registered stage.
  - o_fwd_data = o_wb_data.
  - Lets the decode stage bypass a write that lands in the same cycle.
- Undefined: these ports and their logic do not exist; the core behaviour above is unchanged.

Test Plan:
- Reset check:
  - Stimulus: assert i_rst mid-cycle while o_wb_en=1.
  - Response: o_wb_en drops to 0 before the next edge, ages are 0, o_src_ready=0.
- Single transfer:
  - Stimulus: src2 valid, rd=5, data=0xDEADBEEF, others idle.
  - Response: o_src_ready=4'b0100 that cycle; next cycle o_wb_en=1, rd=5, data=0xDEADBEEF; the cycle after, o_wb_en=0.
- Fixed priority:
  - Stimulus: src0 (rd=1, data=0x11) and src3 (rd=3, data=0x33) valid together.
  - Response: src0 granted cycle 0, src3 granted cycle 1; writes appear at cycles 1 and 2 in that order.
- Anti-starvation:
  - Stimulus: src0 valid every cycle with new data; src1 valid continuously; STARVE_LIMIT=7.
  - Response: src1 ages 0..7, is granted on the 8th cycle of waiting, and src0 stalls exactly that one cycle.
- x0 drop:
  - Stimulus: src1 valid, rd=0, data=0x5.
  - Response: ready=4'b0010; next cycle o_wb_en=0; o_busy=0.
- Forwarding (WBU_ARB_FWD_EN defined):
  - Stimulus: write to rd=9 with data=0xCAFE registered; i_fwd_rs1=9, i_fwd_rs2=0.
  - Response: o_fwd_rs1_hit=1, o_fwd_rs2_hit=0, o_fwd_data=0xCAFE.

Source files
------------

// File: rtl/wbu_arb.sv
// Multi-source writeback arbiter: lowest index wins, with aging to stop starvation, and a
// registered register-file write. Optional forwarding ports are enabled by WBU_ARB_FWD_EN.
module wbu_arb #(
    parameter int unsigned NUM_SRC      = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned RD_WIDTH     = 5,
    parameter int unsigned STARVE_LIMIT = 7
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_SRC-1:0]            i_src_valid,
    input  logic [NUM_SRC*RD_WIDTH-1:0]   i_src_rd,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] i_src_data,
    output logic [NUM_SRC-1:0]            o_src_ready,
`ifdef WBU_ARB_FWD_EN
    input  logic [RD_WIDTH-1:0]           i_fwd_rs1,
    input  logic [RD_WIDTH-1:0]           i_fwd_rs2,
    output logic                          o_fwd_rs1_hit,
    output logic                          o_fwd_rs2_hit,
    output logic [DATA_WIDTH-1:0]         o_fwd_data,
`endif
    output logic                          o_wb_en,
    output logic [RD_WIDTH-1:0]           o_wb_rd,
    output logic [DATA_WIDTH-1:0]         o_wb_data,
    output logic                          o_busy
);

    localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    logic [AGE_W-1:0]      age_q [NUM_SRC];
    logic [AGE_W-1:0]      age_d [NUM_SRC];
    logic [NUM_SRC-1:0]    urgent;
    logic [NUM_SRC-1:0]    grant;
    logic [RD_WIDTH-1:0]   sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;

    function automatic logic [NUM_SRC-1:0] lowest_one(input logic [NUM_SRC-1:0] v);
        return v & (~v + NUM_SRC'(1));
    endfunction

    always_comb begin
        urgent = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            urgent[k] = i_src_valid[k] && (age_q[k] == AGE_MAX);
        end
        grant = '0;
        if (!i_rst) begin
            grant = (|urgent) ? lowest_one(urgent) : lowest_one(i_src_valid);
        end
    end

    // Grant is one-hot or zero, so an AND-OR mux selects the winner.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            sel_rd   = sel_rd | ({RD_WIDTH{grant[k]}} & i_src_rd[k*RD_WIDTH +: RD_WIDTH]);
            sel_data = sel_data | ({DATA_WIDTH{grant[k]}} & i_src_data[k*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            age_d[k] = age_q[k];
            if (!i_src_valid[k] || grant[k]) begin
                age_d[k] = '0;
            end else if (age_q[k] != AGE_MAX) begin
                age_d[k] = age_q[k] + AGE_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                age_q[k] <= '0;
            end
            o_wb_en   <= 1'b0;
            o_wb_rd   <= '0;
            o_wb_data <= '0;
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                age_q[k] <= age_d[k];
            end
            if (|grant) begin
                o_wb_en   <= (sel_rd != '0);
                o_wb_rd   <= sel_rd;
                o_wb_data <= sel_data;
            end else begin
                o_wb_en <= 1'b0;
            end
        end
    end

    assign o_src_ready = grant;
    assign o_busy      = |(i_src_valid & ~grant);

`ifdef WBU_ARB_FWD_EN
    assign o_fwd_rs1_hit = o_wb_en && (o_wb_rd == i_fwd_rs1) && (i_fwd_rs1 != '0);
    assign o_fwd_rs2_hit = o_wb_en && (o_wb_rd == i_fwd_rs2) && (i_fwd_rs2 != '0);
    assign o_fwd_data    = o_wb_data;
`endif

endmodule

// File: tb/tb_wbu_arb.sv
// Bench for wbu_arb: per-source request queues, a behavioural arbitration model checked
// every cycle, and directed scenarios with literal expectations.
module tb_wbu_arb;

    localparam int NS  = 4;
    localparam int DW  = 32;
    localparam int RW  = 5;
    localparam int LIM = 7;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic [NS-1:0]   i_src_valid;
    logic [NS*RW-1:0] i_src_rd;
    logic [NS*DW-1:0] i_src_data;
    logic [NS-1:0]   o_src_ready;
    logic            o_wb_en;
    logic [RW-1:0]   o_wb_rd;
    logic [DW-1:0]   o_wb_data;
    logic            o_busy;
    logic [RW-1:0]   i_fwd_rs1;
    logic [RW-1:0]   i_fwd_rs2;
`ifdef WBU_ARB_FWD_EN
    logic            o_fwd_rs1_hit;
    logic            o_fwd_rs2_hit;
    logic [DW-1:0]   o_fwd_data;
`endif

    wbu_arb #(.NUM_SRC(NS), .DATA_WIDTH(DW), .RD_WIDTH(RW), .STARVE_LIMIT(LIM)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_src_valid  (i_src_valid),
        .i_src_rd     (i_src_rd),
        .i_src_data   (i_src_data),
        .o_src_ready  (o_src_ready),
`ifdef WBU_ARB_FWD_EN
        .i_fwd_rs1    (i_fwd_rs1),
        .i_fwd_rs2    (i_fwd_rs2),
        .o_fwd_rs1_hit(o_fwd_rs1_hit),
        .o_fwd_rs2_hit(o_fwd_rs2_hit),
        .o_fwd_data   (o_fwd_data),
`endif
        .o_wb_en      (o_wb_en),
        .o_wb_rd      (o_wb_rd),
        .o_wb_data    (o_wb_data),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-source request queues; the head is presented until it is granted.
    logic [RW-1:0] item_rd   [NS][16];
    logic [DW-1:0] item_data [NS][16];
    int head [NS];
    int tail [NS];

    task automatic push(input int k, input logic [RW-1:0] rd, input logic [DW-1:0] data);
        item_rd[k][tail[k]]   = rd;
        item_data[k][tail[k]] = data;
        tail[k]++;
    endtask

    task automatic drive();
        for (int k = 0; k < NS; k++) begin
            if (head[k] < tail[k]) begin
                i_src_valid[k]           = 1'b1;
                i_src_rd[k*RW +: RW]     = item_rd[k][head[k]];
                i_src_data[k*DW +: DW]   = item_data[k][head[k]];
            end else begin
                i_src_valid[k]           = 1'b0;
                i_src_rd[k*RW +: RW]     = '0;
                i_src_data[k*DW +: DW]   = '0;
            end
        end
    endtask

    // Samples outputs mid-cycle, then advances one cycle, retiring any granted head.
    task automatic tick(output logic [NS-1:0] rdy, output logic en, output logic [RW-1:0] rd,
                        output logic [DW-1:0] dat, output logic busy);
        @(negedge i_clk);
        rdy  = o_src_ready;
        en   = o_wb_en;
        rd   = o_wb_rd;
        dat  = o_wb_data;
        busy = o_busy;
        @(posedge i_clk);
        #1;
        for (int k = 0; k < NS; k++) if (rdy[k]) head[k]++;
        drive();
    endtask

    // Model: each source's wait count grows while it is refused; once it reaches the limit
    // it beats every non-urgent source, lowest index first among urgent ones.
    int            waits [NS];
    logic          exp_en = 1'b0;
    logic [RW-1:0] exp_rd = '0;
    logic [DW-1:0] exp_data = '0;
    logic [NS-1:0] mg;

    function automatic logic [NS-1:0] model_grant();
        logic [NS-1:0] g = '0;
        if (i_rst) return g;
        for (int k = 0; k < NS; k++)
            if (i_src_valid[k] && waits[k] >= LIM) begin g[k] = 1'b1; return g; end
        for (int k = 0; k < NS; k++)
            if (i_src_valid[k]) begin g[k] = 1'b1; return g; end
        return g;
    endfunction

    always_comb mg = model_grant();

    initial for (int k = 0; k < NS; k++) waits[k] = 0;

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < NS; k++) waits[k] <= 0;
            exp_en   <= 1'b0;
            exp_rd   <= '0;
            exp_data <= '0;
        end else begin
            exp_en <= 1'b0;
            for (int k = 0; k < NS; k++) begin
                if (mg[k]) begin
                    exp_en   <= (i_src_rd[k*RW +: RW] != 0);
                    exp_rd   <= i_src_rd[k*RW +: RW];
                    exp_data <= i_src_data[k*DW +: DW];
                end
                if (!i_src_valid[k] || mg[k]) waits[k] <= 0;
                else waits[k] <= waits[k] + 1;
            end
        end
    end

    always @(negedge i_clk) begin
        if (cyc >= 2) begin
            check("model_ready", o_src_ready, mg);
            check("model_busy", o_busy, |(i_src_valid & ~mg));
            check("model_wb_en", o_wb_en, exp_en);
            check("model_wb_rd", o_wb_rd, exp_rd);
            check("model_wb_data", o_wb_data, exp_data);
`ifdef WBU_ARB_FWD_EN
            check("model_fwd1", o_fwd_rs1_hit, exp_en && exp_rd == i_fwd_rs1 && i_fwd_rs1 != 0);
            check("model_fwd2", o_fwd_rs2_hit, exp_en && exp_rd == i_fwd_rs2 && i_fwd_rs2 != 0);
`endif
        end
    end

    logic [NS-1:0] r;
    logic          e, b;
    logic [RW-1:0] d_rd;
    logic [DW-1:0] d_dat;

    initial begin
        for (int k = 0; k < NS; k++) begin head[k] = 0; tail[k] = 0; end
        i_rst = 1'b1;
        i_fwd_rs1 = '0;
        i_fwd_rs2 = '0;
        drive();
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_wb_en", o_wb_en, 0);
        check("rst_wb_rd", o_wb_rd, 0);
        check("rst_wb_data", o_wb_data, 0);
        check("rst_ready", o_src_ready, 0);
        i_rst = 1'b0;
        tick(r, e, d_rd, d_dat, b);

        // Single transfer from source 2
        push(2, 5'd5, 32'hDEADBEEF);
        drive();
        tick(r, e, d_rd, d_dat, b);
        check("single_ready", r, 4'b0100);
        tick(r, e, d_rd, d_dat, b);
        check("single_wb_en", e, 1);
        check("single_wb_rd", d_rd, 5);
        check("single_wb_data", d_dat, 32'hDEADBEEF);
        tick(r, e, d_rd, d_dat, b);
        check("single_wb_idle", e, 0);

        // Fixed priority: source 0 beats source 3
        push(0, 5'd1, 32'h11);
        push(3, 5'd3, 32'h33);
        drive();
        tick(r, e, d_rd, d_dat, b);
        check("prio_c0_ready", r, 4'b0001);
        check("prio_c0_busy", b, 1);
        tick(r, e, d_rd, d_dat, b);
        check("prio_c1_ready", r, 4'b1000);
        check("prio_c1_rd", d_rd, 1);
        check("prio_c1_data", d_dat, 32'h11);
        tick(r, e, d_rd, d_dat, b);
        check("prio_c2_rd", d_rd, 3);
        check("prio_c2_data", d_dat, 32'h33);
        tick(r, e, d_rd, d_dat, b);

        // Anti-starvation: source 1 waits 7 cycles, is granted on the 8th
        for (int i = 0; i < 10; i++) push(0, 5'd2, 32'h100 + i);
        push(1, 5'd7, 32'h77);
        drive();
        for (int t = 0; t < 12; t++) begin
            tick(r, e, d_rd, d_dat, b);
            if (t < 7) check("starve_src0", r, 4'b0001);
            if (t == 7) begin
                check("starve_src1", r, 4'b0010);
                check("starve_prev_data", d_dat, 32'h106);
            end
            if (t == 8) begin
                check("starve_resume", r, 4'b0001);
                check("starve_wb_rd", d_rd, 7);
                check("starve_wb_data", d_dat, 32'h77);
            end
            if (t == 9) check("starve_next_data", d_dat, 32'h107);
        end

        // rd==0 is accepted but never written
        push(1, 5'd0, 32'h5);
        drive();
        tick(r, e, d_rd, d_dat, b);
        check("x0_ready", r, 4'b0010);
        check("x0_busy", b, 0);
        tick(r, e, d_rd, d_dat, b);
        check("x0_wb_en", e, 0);

        // Write to rd=9 registered, forwarding probe, then reset mid-cycle
        push(2, 5'd9, 32'hCAFE);
        push(3, 5'd10, 32'hAB);
        drive();
        tick(r, e, d_rd, d_dat, b);
        check("pre_rst_ready", r, 4'b0100);
        check("pre_rst_wb_en", o_wb_en, 1);
        i_fwd_rs1 = 5'd9;
        i_fwd_rs2 = 5'd0;
        #1;
`ifdef WBU_ARB_FWD_EN
        check("fwd_rs1_hit", o_fwd_rs1_hit, 1);
        check("fwd_rs2_hit", o_fwd_rs2_hit, 0);
        check("fwd_data", o_fwd_data, 32'hCAFE);
`endif
        #1;
        i_rst = 1'b1;
        #1;
        check("midrst_wb_en", o_wb_en, 0);
        check("midrst_ready", o_src_ready, 0);
        check("midrst_busy", o_busy, 1);
        tick(r, e, d_rd, d_dat, b);
        tick(r, e, d_rd, d_dat, b);
        check("rst_hold_ready", r, 4'b0000);
        i_rst = 1'b0;
        tick(r, e, d_rd, d_dat, b);
        check("post_rst_ready", r, 4'b1000);
        tick(r, e, d_rd, d_dat, b);
        check("post_rst_wb_rd", d_rd, 10);
        check("post_rst_wb_data", d_dat, 32'hAB);
        tick(r, e, d_rd, d_dat, b);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
